// File: rtl/alu_j_core.sv
// -----------------------------------------------------------------------------
// alu_j_core : small ALU with a combinational result path and a registered copy
//
// Ports
//   clk       in   rising-edge clock for the registered copy
//   rst_n     in   asynchronous active-low reset of result_q/status_q
//   opcode    in   operation select (NOP/ADD/SUB/AND/OR/NOT/SHL/SHR/VAL)
//   operand1  in   first operand
//   operand2  in   second operand
//   param     in   immediate value / shift amount
//   result    out  combinational result
//   status    out  combinational flags: [0] carry/borrow, [1] zero, [2] negative
//   result_q  out  registered result, loaded on any operation other than NOP
//   status_q  out  registered status, loaded alongside result_q
//
// Optional feature macro: ALU_J_ROTATE_EN adds ROL (01001) and ROR (01010),
// rotating operand1 by the low log2(DATA_WIDTH) bits of param. Without the
// macro those opcodes decode as NOP.
// -----------------------------------------------------------------------------
module alu_j_core #(
  parameter int DATA_WIDTH      = 8,
  parameter int NUM_OPCODE_BITS = 5,
  parameter int PARAM_BITS      = 8,
  parameter int NUM_STATUS_BITS = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_OPCODE_BITS-1:0] opcode,
  input  logic [DATA_WIDTH-1:0]      operand1,
  input  logic [DATA_WIDTH-1:0]      operand2,
  input  logic [PARAM_BITS-1:0]      param,
  output logic [DATA_WIDTH-1:0]      result,
  output logic [NUM_STATUS_BITS-1:0] status,
  output logic [DATA_WIDTH-1:0]      result_q,
  output logic [NUM_STATUS_BITS-1:0] status_q
);

  localparam logic [NUM_OPCODE_BITS-1:0] OP_NOP = NUM_OPCODE_BITS'(5'b00000);
  localparam logic [NUM_OPCODE_BITS-1:0] OP_ADD = NUM_OPCODE_BITS'(5'b00001);
  localparam logic [NUM_OPCODE_BITS-1:0] OP_SUB = NUM_OPCODE_BITS'(5'b00010);
  localparam logic [NUM_OPCODE_BITS-1:0] OP_AND = NUM_OPCODE_BITS'(5'b00011);
  localparam logic [NUM_OPCODE_BITS-1:0] OP_OR  = NUM_OPCODE_BITS'(5'b00100);
  localparam logic [NUM_OPCODE_BITS-1:0] OP_NOT = NUM_OPCODE_BITS'(5'b00101);
  localparam logic [NUM_OPCODE_BITS-1:0] OP_SHL = NUM_OPCODE_BITS'(5'b00110);
  localparam logic [NUM_OPCODE_BITS-1:0] OP_SHR = NUM_OPCODE_BITS'(5'b00111);
  localparam logic [NUM_OPCODE_BITS-1:0] OP_VAL = NUM_OPCODE_BITS'(5'b01000);
`ifdef ALU_J_ROTATE_EN
  localparam logic [NUM_OPCODE_BITS-1:0] OP_ROL = NUM_OPCODE_BITS'(5'b01001);
  localparam logic [NUM_OPCODE_BITS-1:0] OP_ROR = NUM_OPCODE_BITS'(5'b01010);
  localparam int ROT_BITS = $clog2(DATA_WIDTH);
`endif

  localparam int ST_CARRY = 0;
  localparam int ST_ZERO  = 1;
  localparam int ST_NEG   = 2;

  logic [DATA_WIDTH:0]          add_ext_s;
  logic [DATA_WIDTH:0]          sub_ext_s;
  logic [DATA_WIDTH:0]          shl_ext_s;
  logic [DATA_WIDTH:0]          shr_ext_s;
  logic [DATA_WIDTH-1:0]        result_s;
  logic                         carry_s;
  logic                         load_s;
  logic [NUM_STATUS_BITS-1:0]   status_s;
  logic [DATA_WIDTH-1:0]        result_q_r;
  logic [NUM_STATUS_BITS-1:0]   status_q_r;

  // One extra bit on each side of the operand catches the carry/borrow and
  // the last bit shifted out; shifting by >= width naturally yields zero.
  assign add_ext_s = {1'b0, operand1} + {1'b0, operand2};
  assign sub_ext_s = {1'b0, operand1} - {1'b0, operand2};
  assign shl_ext_s = {1'b0, operand1} << param;
  assign shr_ext_s = {operand1, 1'b0} >> param;

`ifdef ALU_J_ROTATE_EN
  logic [ROT_BITS-1:0]     rot_amt_s;
  logic [2*DATA_WIDTH-1:0] rol_ext_s;
  logic [2*DATA_WIDTH-1:0] ror_ext_s;

  // Rotation as a shift of the operand concatenated with itself.
  assign rot_amt_s = param[ROT_BITS-1:0];
  assign rol_ext_s = {operand1, operand1} << rot_amt_s;
  assign ror_ext_s = {operand1, operand1} >> rot_amt_s;
`endif

  // Operation decode: result, carry, and whether the registered copy loads.
  always_comb begin
    result_s = '0;
    carry_s  = 1'b0;
    load_s   = 1'b1;
    case (opcode)
      OP_NOP: load_s = 1'b0;
      OP_ADD: begin
        result_s = add_ext_s[DATA_WIDTH-1:0];
        carry_s  = add_ext_s[DATA_WIDTH];
      end
      OP_SUB: begin
        // The borrow lands in the extra top bit exactly when operand1 < operand2.
        result_s = sub_ext_s[DATA_WIDTH-1:0];
        carry_s  = sub_ext_s[DATA_WIDTH];
      end
      OP_AND: result_s = operand1 & operand2;
      OP_OR:  result_s = operand1 | operand2;
      OP_NOT: result_s = ~operand2;
      OP_SHL: begin
        result_s = shl_ext_s[DATA_WIDTH-1:0];
        carry_s  = shl_ext_s[DATA_WIDTH];
      end
      OP_SHR: begin
        result_s = shr_ext_s[DATA_WIDTH:1];
        carry_s  = shr_ext_s[0];
      end
      OP_VAL: result_s = DATA_WIDTH'(param);
`ifdef ALU_J_ROTATE_EN
      OP_ROL: begin
        result_s = rol_ext_s[2*DATA_WIDTH-1:DATA_WIDTH];
        carry_s  = rol_ext_s[DATA_WIDTH];
      end
      OP_ROR: begin
        result_s = ror_ext_s[DATA_WIDTH-1:0];
        carry_s  = ror_ext_s[DATA_WIDTH-1];
      end
`endif
      default: load_s = 1'b0;
    endcase
  end

  // Status flags derived from the selected result for every opcode.
  always_comb begin
    status_s           = '0;
    status_s[ST_CARRY] = carry_s;
    status_s[ST_ZERO]  = (result_s == '0);
    status_s[ST_NEG]   = result_s[DATA_WIDTH-1];
  end

  // Registered copy: loads on real operations, holds on NOP/unlisted opcodes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q_r <= '0;
      status_q_r <= '0;
    end else if (load_s) begin
      result_q_r <= result_s;
      status_q_r <= status_s;
    end
  end

  assign result   = result_s;
  assign status   = status_s;
  assign result_q = result_q_r;
  assign status_q = status_q_r;

endmodule

// File: tb/tb_alu_j_core.sv
`timescale 1ns/1ps
module tb_alu_j_core;

  typedef struct packed {
    logic [7:0] r;
    logic [2:0] s;
  } exp_t;

  typedef struct packed {
    logic [4:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] p;
  } stim_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] opcode;
  logic [7:0] operand1;
  logic [7:0] operand2;
  logic [7:0] param;
  logic [7:0] result;
  logic [2:0] status;
  logic [7:0] result_q;
  logic [2:0] status_q;

  int   tests_run    = 0;
  int   tests_failed = 0;
  exp_t comb_q[$];
  exp_t reg_q[$];
  exp_t reg_model;

  always #5 clk = ~clk;

  alu_j_core dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .opcode   (opcode),
    .operand1 (operand1),
    .operand2 (operand2),
    .param    (param),
    .result   (result),
    .status   (status),
    .result_q (result_q),
    .status_q (status_q)
  );

  // Reference model written as plain integer arithmetic and bit-by-bit loops.
  function automatic exp_t model(input logic [4:0] op, input logic [7:0] a,
                                 input logic [7:0] b, input logic [7:0] p);
    int   v;
    logic c;
    exp_t e;
    v = 0;
    c = 1'b0;
    case (op)
      5'd1: begin v = int'(a) + int'(b); c = (v > 255); v = v % 256; end
      5'd2: begin v = int'(a) - int'(b); c = (v < 0); if (v < 0) v = v + 256; end
      5'd3: v = int'(a & b);
      5'd4: v = int'(a | b);
      5'd5: v = int'(~b);
      5'd6: begin
        v = int'(a);
        for (int i = 0; i < int'(p); i++) begin c = v[7]; v = (v << 1) & 255; end
      end
      5'd7: begin
        v = int'(a);
        for (int i = 0; i < int'(p); i++) begin c = v[0]; v = v >> 1; end
      end
      5'd8: v = int'(p);
`ifdef ALU_J_ROTATE_EN
      5'd9: begin
        v = int'(a);
        for (int i = 0; i < int'(p) % 8; i++) v = ((v << 1) | (v >> 7)) & 255;
        c = v[0];
      end
      5'd10: begin
        v = int'(a);
        for (int i = 0; i < int'(p) % 8; i++) v = (v >> 1) | ((v & 1) << 7);
        c = v[7];
      end
`endif
      default: v = 0;
    endcase
    e.r = v[7:0];
    e.s = {v[7], (v == 0), c};
    return e;
  endfunction

  function automatic logic loads(input logic [4:0] op);
`ifdef ALU_J_ROTATE_EN
    return (op >= 5'd1) && (op <= 5'd10);
`else
    return (op >= 5'd1) && (op <= 5'd8);
`endif
  endfunction

  // Apply inputs at the falling edge and record the expected outputs.
  task automatic drive(input stim_t st);
    @(negedge clk);
    opcode   = st.op;
    operand1 = st.a;
    operand2 = st.b;
    param    = st.p;
    comb_q.push_back(model(st.op, st.a, st.b, st.p));
    if (loads(st.op)) reg_model = model(st.op, st.a, st.b, st.p);
  endtask

  task automatic test_reset();
    exp_t e;
    rst_n = 1'b0; opcode = 5'd0; operand1 = 8'd0; operand2 = 8'd0; param = 8'd0;
    #1;
    tests_run++;
    if (result_q !== 8'd0 || status_q !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_regs: got %h/%b want 00/000", result_q, status_q);
    end
    e = model(5'd0, 8'd0, 8'd0, 8'd0);
    tests_run++;
    if (result !== e.r || status !== e.s) begin
      tests_failed++;
      $display("FAIL reset_nop_comb: got %h/%b want %h/%b", result, status, e.r, e.s);
    end
    @(negedge clk);
    rst_n = 1'b1;
    reg_model = '0;
  endtask

  task automatic test_arith_logic();
    stim_t tbl[8];
    exp_t  e;
    tbl = '{'{5'd1, 8'd1,   8'd3,   8'd0}, '{5'd1, 8'd4,   8'd6,   8'd0},
            '{5'd1, 8'd255, 8'd2,   8'd0}, '{5'd2, 8'd3,   8'd5,   8'd0},
            '{5'd2, 8'd9,   8'd9,   8'd0}, '{5'd3, 8'hCC,  8'hAA,  8'd0},
            '{5'd4, 8'h5C,  8'hAC,  8'd0}, '{5'd5, 8'hFF,  8'hAC,  8'd0}};
    foreach (tbl[i]) begin
      drive(tbl[i]);
      #1;
      e = comb_q.pop_front();
      tests_run++;
      if (result !== e.r || status !== e.s) begin
        tests_failed++;
        $display("FAIL arith_logic[%0d]: got %h/%b want %h/%b", i, result, status, e.r, e.s);
      end
    end
  endtask

  task automatic test_shift();
    stim_t tbl[9];
    exp_t  e;
    tbl = '{'{5'd6, 8'h81, 8'd0, 8'd1}, '{5'd6, 8'h81, 8'd0, 8'd0},
            '{5'd6, 8'h01, 8'd0, 8'd8}, '{5'd6, 8'hFF, 8'd0, 8'd9},
            '{5'd6, 8'h5A, 8'd0, 8'd3}, '{5'd7, 8'h01, 8'd0, 8'd8},
            '{5'd7, 8'h80, 8'd0, 8'd8}, '{5'd7, 8'hB6, 8'd0, 8'd2},
            '{5'd7, 8'hFF, 8'd0, 8'd200}};
    foreach (tbl[i]) begin
      drive(tbl[i]);
      #1;
      e = comb_q.pop_front();
      tests_run++;
      if (result !== e.r || status !== e.s) begin
        tests_failed++;
        $display("FAIL shift[%0d]: got %h/%b want %h/%b", i, result, status, e.r, e.s);
      end
    end
  endtask

  task automatic test_rotate_and_unlisted();
    stim_t tbl[5];
    exp_t  e;
    tbl = '{'{5'd9,  8'h81, 8'd0,  8'd1}, '{5'd10, 8'h81, 8'd0, 8'd1},
            '{5'd10, 8'h34, 8'd0,  8'd11}, '{5'd11, 8'hFF, 8'hFF, 8'hFF},
            '{5'd31, 8'h80, 8'h80, 8'h80}};
    foreach (tbl[i]) begin
      drive(tbl[i]);
      reg_q.push_back(reg_model);
      #1;
      e = comb_q.pop_front();
      tests_run++;
      if (result !== e.r || status !== e.s) begin
        tests_failed++;
        $display("FAIL rot_unlisted[%0d]: got %h/%b want %h/%b", i, result, status, e.r, e.s);
      end
      @(posedge clk);
      #1;
      e = reg_q.pop_front();
      tests_run++;
      if (result_q !== e.r || status_q !== e.s) begin
        tests_failed++;
        $display("FAIL rot_unlisted_reg[%0d]: got %h/%b want %h/%b", i, result_q, status_q, e.r, e.s);
      end
    end
  endtask

  task automatic test_val_hold_reset();
    exp_t e;
    drive('{5'd8, 8'h00, 8'h00, 8'h5A});
    void'(comb_q.pop_front());
    @(posedge clk);
    #1;
    tests_run++;
    if (result_q !== 8'h5A || status_q !== 3'b000) begin
      tests_failed++;
      $display("FAIL val_load: got %h/%b want 5a/000", result_q, status_q);
    end
    drive('{5'd0, 8'hFF, 8'hFF, 8'h11});
    void'(comb_q.pop_front());
    @(posedge clk);
    #1;
    tests_run++;
    if (result_q !== 8'h5A || status_q !== 3'b000) begin
      tests_failed++;
      $display("FAIL nop_hold: got %h/%b want 5a/000", result_q, status_q);
    end
    drive('{5'd1, 8'd4, 8'd6, 8'd0});
    e = comb_q.pop_front();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (result_q !== 8'd0 || status_q !== 3'b000) begin
      tests_failed++;
      $display("FAIL async_reset: got %h/%b want 00/000", result_q, status_q);
    end
    tests_run++;
    if (result !== e.r || status !== e.s) begin
      tests_failed++;
      $display("FAIL comb_in_reset: got %h/%b want %h/%b", result, status, e.r, e.s);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (result_q !== 8'd0) begin
      tests_failed++;
      $display("FAIL reset_hold: got %h want 00", result_q);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if (result_q !== 8'd10 || status_q !== 3'b000) begin
      tests_failed++;
      $display("FAIL post_reset_load: got %h/%b want 0a/000", result_q, status_q);
    end
    reg_model = '{8'd10, 3'b000};
  endtask

  task automatic test_back_to_back();
    stim_t st;
    exp_t  e;
    for (int i = 0; i < 40; i++) begin
      st.op = 5'($urandom_range(0, 12));
      st.a  = 8'($urandom_range(0, 255));
      st.b  = 8'($urandom_range(0, 255));
      st.p  = 8'($urandom_range(0, 10));
      drive(st);
      reg_q.push_back(reg_model);
      #1;
      e = comb_q.pop_front();
      tests_run++;
      if (result !== e.r || status !== e.s) begin
        tests_failed++;
        $display("FAIL b2b_comb[%0d] op=%0d: got %h/%b want %h/%b", i, st.op, result, status, e.r, e.s);
      end
      @(posedge clk);
      #1;
      e = reg_q.pop_front();
      tests_run++;
      if (result_q !== e.r || status_q !== e.s) begin
        tests_failed++;
        $display("FAIL b2b_reg[%0d] op=%0d: got %h/%b want %h/%b", i, st.op, result_q, status_q, e.r, e.s);
      end
    end
  endtask

  initial begin
    test_reset();
    test_arith_logic();
    test_shift();
    test_rotate_and_unlisted();
    test_val_hold_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
